lpc_host: RTL and testbench

LPC bus initiator that runs one LPC I/O or memory cycle per request.
- Drives START, CYCTYPE/DIR, address and write data onto the bus, then turns the bus around.
- Waits for peripheral SYNC, captures read data and returns a single-cycle response.
- Serves as the active counterpart to the passive LPC decoder: used to inject test cycles (port 80 writes, TPM memory reads) onto a bench bus or a real target.
- Runs entirely in the LPC clock domain.

---
 rtl/lpc_host.sv | 240 ++++++++++++++++++++++++
 tb/tb_lpc_host.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host.sv
// lpc_host: LPC bus initiator. Runs one I/O or memory cycle per request:
// START, CYCTYPE/DIR, address, optional write data, turnaround, SYNC wait,
// optional read data, peripheral turnaround, then a one-cycle response.
// All bus outputs are registered and change together with the FSM state.
module lpc_host #(
   parameter int SYNC_TIMEOUT    = 8,
   parameter int LONG_WAIT_LIMIT = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cyctype_dir,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_sync_timeout,
   output logic        rsp_sync_error,
   input  logic [3:0]  lpc_ad_in,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   output logic        lpc_frame
);

   localparam int MAXLIM = (LONG_WAIT_LIMIT > SYNC_TIMEOUT) ? LONG_WAIT_LIMIT : SYNC_TIMEOUT;
   localparam int CW     = $clog2(MAXLIM + 1);
   localparam logic [CW-1:0] C_LIM_S = CW'(SYNC_TIMEOUT);
   localparam logic [CW-1:0] C_LIM_L = CW'(LONG_WAIT_LIMIT);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
      S_SYNC, S_RDATA, S_PTAR, S_ABORT, S_DONE
   } state_t;

   state_t        r_state;
   logic [31:0]   r_addr;      // address shift register, next nibble in [31:28]
   logic [7:0]    r_wdata;
   logic [7:0]    r_rdata;
   logic [3:0]    r_ctd;
   logic          r_mem;
   logic          r_wr;
   logic          r_err;       // peripheral answered SYNC 1010
   logic          r_long;      // long-wait nibble seen in this SYNC phase
   logic [3:0]    r_cnt;       // nibble / turnaround / abort sub-counter
   logic [CW-1:0] r_wait;      // consecutive non-ready SYNC cycles

   logic          r_ready;
   logic          r_rsp_valid;
   logic [7:0]    r_rsp_data;
   logic          r_rsp_to;
   logic          r_rsp_err;
   logic [3:0]    r_ad_out;
   logic          r_ad_oe;
   logic          r_frame;

   logic          w_unsup;
   logic          w_sync_rdy;
   logic          w_long_now;
   logic [CW-1:0] w_wait_nx;
   logic [CW-1:0] w_lim;
   logic [3:0]    w_addr_last;

   // Unsupported cyctypes: anything beyond I/O or memory, or a set reserved bit 0.
   assign w_unsup     = req_cyctype_dir[3] | req_cyctype_dir[0];
   assign w_sync_rdy  = (lpc_ad_in == 4'b0000) || (lpc_ad_in == 4'b1010);
   assign w_long_now  = r_long || (lpc_ad_in == 4'b0110);
   assign w_wait_nx   = r_wait + 1'b1;
   assign w_lim       = w_long_now ? C_LIM_L : C_LIM_S;
   assign w_addr_last = r_mem ? 4'd8 : 4'd4;

   // Cycle sequencer: state, captured request and every registered output.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_ctd       <= '0;
         r_mem       <= 1'b0;
         r_wr        <= 1'b0;
         r_err       <= 1'b0;
         r_long      <= 1'b0;
         r_cnt       <= '0;
         r_wait      <= '0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_to    <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_ad_out    <= 4'hF;
         r_ad_oe     <= 1'b0;
         r_frame     <= 1'b1;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               r_frame <= 1'b1;
               r_ad_oe <= 1'b0;
               if (req_valid && r_ready) begin
                  r_ready <= 1'b0;
                  r_ctd   <= req_cyctype_dir;
                  r_mem   <= req_cyctype_dir[2];
                  r_wr    <= req_cyctype_dir[1];
                  r_wdata <= req_data;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
                  // I/O addresses are pre-aligned so both widths shift out of [31:28].
                  r_addr  <= req_cyctype_dir[2] ? req_addr : {req_addr[15:0], 16'h0000};
                  if (w_unsup) begin
                     r_state     <= S_DONE;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= 8'h00;
                     r_rsp_to    <= 1'b0;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state  <= S_START;
                     r_frame  <= 1'b0;
                     r_ad_out <= 4'b0000;
                     r_ad_oe  <= 1'b1;
                  end
               end
            end
            S_START: begin
               r_state  <= S_CYCTYPE;
               r_frame  <= 1'b1;
               r_ad_out <= r_ctd;
            end
            S_CYCTYPE: begin
               r_state  <= S_ADDR;
               r_ad_out <= r_addr[31:28];
               r_addr   <= {r_addr[27:0], 4'h0};
               r_cnt    <= 4'd1;
            end
            S_ADDR: begin
               if (r_cnt != w_addr_last) begin
                  r_ad_out <= r_addr[31:28];
                  r_addr   <= {r_addr[27:0], 4'h0};
                  r_cnt    <= r_cnt + 4'd1;
               end else if (r_wr) begin
                  r_state  <= S_WDATA;
                  r_ad_out <= r_wdata[3:0];
                  r_cnt    <= 4'd0;
               end else begin
                  r_state  <= S_TAR1;
                  r_ad_out <= 4'hF;
               end
            end
            S_WDATA: begin
               if (r_cnt == 4'd0) begin
                  r_ad_out <= r_wdata[7:4];
                  r_cnt    <= 4'd1;
               end else begin
                  r_state  <= S_TAR1;
                  r_ad_out <= 4'hF;
               end
            end
            S_TAR1: begin
               r_state  <= S_TAR2;
               r_ad_oe  <= 1'b0;
               r_ad_out <= 4'hF;
               r_wait   <= '0;
               r_long   <= 1'b0;
            end
            S_TAR2: begin
               r_state <= S_SYNC;
            end
            S_SYNC: begin
               if (w_sync_rdy) begin
                  r_err   <= (lpc_ad_in == 4'b1010);
                  r_state <= r_wr ? S_PTAR : S_RDATA;
                  r_cnt   <= 4'd0;
               end else begin
                  r_long <= w_long_now;
                  r_wait <= w_wait_nx;
                  if (w_wait_nx >= w_lim) begin
                     r_state  <= S_ABORT;
                     r_frame  <= 1'b0;
                     r_ad_out <= 4'hF;
                     r_ad_oe  <= 1'b1;
                     r_cnt    <= 4'd1;
                  end
               end
            end
            S_RDATA: begin
               if (r_cnt == 4'd0) begin
                  r_rdata[3:0] <= lpc_ad_in;
                  r_cnt        <= 4'd1;
               end else begin
                  r_rdata[7:4] <= lpc_ad_in;
                  r_state      <= S_PTAR;
                  r_cnt        <= 4'd0;
               end
            end
            S_PTAR: begin
               if (r_cnt == 4'd0) begin
                  r_cnt <= 4'd1;
               end else begin
                  r_state     <= S_DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_wr ? 8'h00 : r_rdata;
                  r_rsp_to    <= 1'b0;
                  r_rsp_err   <= r_err;
               end
            end
            S_ABORT: begin
               if (r_cnt != 4'd4) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_state     <= S_DONE;
                  r_frame     <= 1'b1;
                  r_ad_oe     <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= 8'hFF;
                  r_rsp_to    <= 1'b1;
                  r_rsp_err   <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready        = r_ready;
   assign rsp_valid        = r_rsp_valid;
   assign rsp_data         = r_rsp_data;
   assign rsp_sync_timeout = r_rsp_to;
   assign rsp_sync_error   = r_rsp_err;
   assign lpc_ad_out       = r_ad_out;
   assign lpc_ad_oe        = r_ad_oe;
   assign lpc_frame        = r_frame;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: directed and randomized LPC cycles checked against a per-cycle
// reference built from the bus protocol rules. A second instance with a
// shortened long-wait limit shares all inputs so both limits are exercised.
module tb_lpc_host;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [3:0]  req_cyctype_dir = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [7:0]  req_data = 8'h0;
   logic [3:0]  lpc_ad_in = 4'hF;

   logic        req_ready, rsp_valid, rsp_sync_timeout, rsp_sync_error, lpc_ad_oe, lpc_frame;
   logic [7:0]  rsp_data;
   logic [3:0]  lpc_ad_out;
   logic        req_ready_b, rsp_valid_b, rsp_sync_timeout_b, rsp_sync_error_b, lpc_ad_oe_b, lpc_frame_b;
   logic [7:0]  rsp_data_b;
   logic [3:0]  lpc_ad_out_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       fr;
      logic       oe;
      logic [3:0] ad;
      logic [3:0] drv;
      logic       rv;
      logic       chkd;
      logic       to;
      logic       er;
      logic [7:0] dat;
   } cyc_t;

   cyc_t       mq[$];
   cyc_t       e0[$];
   cyc_t       e1[$];
   logic [3:0] sq[$];

   lpc_host dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_sync_timeout(rsp_sync_timeout), .rsp_sync_error(rsp_sync_error),
      .lpc_ad_in(lpc_ad_in), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe), .lpc_frame(lpc_frame)
   );

   lpc_host #(.LONG_WAIT_LIMIT(64)) dut64 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_b),
      .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
      .rsp_sync_timeout(rsp_sync_timeout_b), .rsp_sync_error(rsp_sync_error_b),
      .lpc_ad_in(lpc_ad_in), .lpc_ad_out(lpc_ad_out_b), .lpc_ad_oe(lpc_ad_oe_b), .lpc_frame(lpc_frame_b)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cyc_t mk(input logic fr, input logic oe, input logic [3:0] ad, input logic [3:0] drv);
      cyc_t d;
      d.fr = fr; d.oe = oe; d.ad = ad; d.drv = drv;
      d.rv = 1'b0; d.chkd = 1'b1; d.to = 1'b0; d.er = 1'b0; d.dat = 8'h00;
      return d;
   endfunction

   // Expected bus/response per cycle after the accepting edge, for sync script sq.
   task automatic build(input logic [3:0] ctd, input logic [31:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int lim);
      int         n, cnt, i;
      bit         lng, wr, stop, rdy;
      logic [3:0] nb;
      cyc_t       d;
      mq.delete();
      if (ctd[3] || ctd[0]) begin
         d = mk(1'b1, 1'b0, 4'hF, 4'hF);
         d.rv = 1'b1; d.chkd = 1'b0; d.er = 1'b1;
         mq.push_back(d);
      end else begin
         wr = ctd[1];
         n  = ctd[2] ? 8 : 4;
         mq.push_back(mk(1'b0, 1'b1, 4'h0, 4'hF));
         mq.push_back(mk(1'b1, 1'b1, ctd, 4'hF));
         for (int k = n - 1; k >= 0; k--)
            mq.push_back(mk(1'b1, 1'b1, 4'((addr >> (4 * k)) & 32'hF), 4'hF));
         if (wr) begin
            mq.push_back(mk(1'b1, 1'b1, wd[3:0], 4'hF));
            mq.push_back(mk(1'b1, 1'b1, wd[7:4], 4'hF));
         end
         mq.push_back(mk(1'b1, 1'b1, 4'hF, 4'hF));
         mq.push_back(mk(1'b1, 1'b0, 4'hF, 4'hF));
         cnt = 0; lng = 0; i = 0; stop = 0; rdy = 0; nb = 4'hF;
         while (!stop) begin
            nb = (i < sq.size()) ? sq[i] : 4'hF;
            mq.push_back(mk(1'b1, 1'b0, 4'hF, nb));
            if (nb == 4'h0 || nb == 4'hA) begin
               rdy = 1; stop = 1;
            end else begin
               cnt++;
               if (nb == 4'h6) lng = 1;
               if (cnt >= (lng ? lim : 8)) stop = 1;
               i++;
            end
         end
         if (!rdy) begin
            repeat (4) mq.push_back(mk(1'b0, 1'b1, 4'hF, 4'hF));
            d = mk(1'b1, 1'b0, 4'hF, 4'hF);
            d.rv = 1'b1; d.to = 1'b1; d.dat = 8'hFF;
         end else begin
            if (!wr) begin
               mq.push_back(mk(1'b1, 1'b0, 4'hF, rd[3:0]));
               mq.push_back(mk(1'b1, 1'b0, 4'hF, rd[7:4]));
            end
            repeat (2) mq.push_back(mk(1'b1, 1'b0, 4'hF, 4'hF));
            d = mk(1'b1, 1'b0, 4'hF, 4'hF);
            d.rv = 1'b1; d.er = (nb == 4'hA); d.dat = wr ? 8'h00 : rd;
         end
         mq.push_back(d);
      end
   endtask

   task automatic run_txn(input string tag, input logic [3:0] ctd, input logic [31:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd);
      int w;
      build(ctd, addr, wd, rd, 256); e0 = mq;
      build(ctd, addr, wd, rd, 64);  e1 = mq;
      w = 0;
      @(negedge clock);
      while (!(req_ready && req_ready_b) && w < 400) begin @(negedge clock); w++; end
      chk({tag, " ready"}, req_ready, 1);
      req_valid = 1'b1; req_cyctype_dir = ctd; req_addr = addr; req_data = wd;
      @(posedge clock);
      for (int c = 0; c < e0.size(); c++) begin
         @(negedge clock);
         if (c == 0) begin
            req_valid = 1'b0;
            req_cyctype_dir = 4'($urandom); req_addr = $urandom; req_data = 8'($urandom);
         end
         chk($sformatf("%s c%0d frame", tag, c + 1), lpc_frame, e0[c].fr);
         chk($sformatf("%s c%0d oe", tag, c + 1), lpc_ad_oe, e0[c].oe);
         if (e0[c].oe) chk($sformatf("%s c%0d ad", tag, c + 1), lpc_ad_out, e0[c].ad);
         chk($sformatf("%s c%0d rsp_valid", tag, c + 1), rsp_valid, e0[c].rv);
         chk($sformatf("%s c%0d req_ready", tag, c + 1), req_ready, 0);
         if (e0[c].rv) begin
            chk({tag, " timeout"}, rsp_sync_timeout, e0[c].to);
            chk({tag, " error"}, rsp_sync_error, e0[c].er);
            if (e0[c].chkd) chk({tag, " data"}, rsp_data, e0[c].dat);
         end
         if (c < e1.size()) begin
            chk($sformatf("%s c%0d rsp_valid64", tag, c + 1), rsp_valid_b, e1[c].rv);
            if (e1[c].rv) begin
               chk({tag, " timeout64"}, rsp_sync_timeout_b, e1[c].to);
               if (e1[c].chkd) chk({tag, " data64"}, rsp_data_b, e1[c].dat);
            end
         end else begin
            chk($sformatf("%s c%0d rsp_valid64 idle", tag, c + 1), rsp_valid_b, 0);
         end
         lpc_ad_in = e0[c].drv;
      end
      @(negedge clock);
      lpc_ad_in = 4'hF;
      chk({tag, " post rsp_valid"}, rsp_valid, 0);
      chk({tag, " post req_ready"}, req_ready, 1);
      chk({tag, " hold timeout"}, rsp_sync_timeout, e0[e0.size() - 1].to);
      chk({tag, " hold error"}, rsp_sync_error, e0[e0.size() - 1].er);
      if (e0[e0.size() - 1].chkd) chk({tag, " hold data"}, rsp_data, e0[e0.size() - 1].dat);
   endtask

   initial begin
      logic [3:0] ctds[4];
      logic [3:0] waits[4];
      logic [3:0] c4;
      int k;
      ctds[0] = 4'b0000; ctds[1] = 4'b0010; ctds[2] = 4'b0100; ctds[3] = 4'b0110;
      waits[0] = 4'h5; waits[1] = 4'hF; waits[2] = 4'h3; waits[3] = 4'h9;

      // Reset values
      repeat (3) @(negedge clock);
      chk("rst frame", lpc_frame, 1);
      chk("rst ad_out", lpc_ad_out, 4'hF);
      chk("rst oe", lpc_ad_oe, 0);
      chk("rst ready", req_ready, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_data", rsp_data, 0);
      chk("rst timeout", rsp_sync_timeout, 0);
      chk("rst error", rsp_sync_error, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("ready after reset", req_ready, 1);

      // Directed cycles from the bus scenarios
      sq = '{4'h0};
      run_txn("iow80", 4'b0010, 32'h0000_0080, 8'h34, 8'h00);
      sq = '{4'h5, 4'h5, 4'h5, 4'h0};
      run_txn("memrd_tpm", 4'b0100, 32'hFED4_0014, 8'h00, 8'hA5);
      sq.delete();
      run_txn("ior_timeout", 4'b0000, 32'h0000_1234, 8'h00, 8'h77);
      sq = '{4'hA};
      run_txn("iow_err", 4'b0010, 32'h0000_0080, 8'h5A, 8'h00);
      sq.delete();
      for (int i = 0; i < 101; i++) sq.push_back(4'h6);
      sq.push_back(4'h0);
      run_txn("memrd_long", 4'b0100, 32'h1234_5678, 8'h00, 8'h3C);
      sq.delete();
      repeat (7) sq.push_back(4'hF);
      sq.push_back(4'h0);
      run_txn("ior_7wait", 4'b0000, 32'h0000_0060, 8'h00, 8'hC3);
      sq.delete();
      repeat (8) sq.push_back(4'h5);
      sq.push_back(4'h0);
      run_txn("memw_8wait", 4'b0110, 32'hDEAD_BEEF, 8'h81, 8'h00);
      sq.delete();
      run_txn("unsup_1000", 4'b1000, 32'h0000_0080, 8'h11, 8'h00);
      run_txn("unsup_0001", 4'b0001, 32'h0000_0080, 8'h11, 8'h00);
      run_txn("unsup_1110", 4'b1110, 32'hFFFF_FFFF, 8'h11, 8'h00);

      // Randomized cycles
      for (int t = 0; t < 24; t++) begin
         sq.delete();
         if ($urandom_range(0, 7) != 0) begin
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) sq.push_back(waits[$urandom_range(0, 3)]);
            sq.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
         end
         c4 = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ctds[$urandom_range(0, 3)];
         run_txn($sformatf("rnd%0d", t), c4, $urandom, 8'($urandom), 8'($urandom));
      end

      // Reset during the address phase abandons the cycle
      sq = '{4'h0};
      build(4'b0010, 32'h0000_0080, 8'h34, 8'h00, 256); e0 = mq;
      @(negedge clock);
      chk("mid ready", req_ready, 1);
      req_valid = 1'b1; req_cyctype_dir = 4'b0010; req_addr = 32'h80; req_data = 8'h34;
      @(posedge clock);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         req_valid = 1'b0;
         chk($sformatf("mid c%0d frame", c + 1), lpc_frame, e0[c].fr);
         chk($sformatf("mid c%0d ad", c + 1), lpc_ad_out, e0[c].ad);
      end
      reset = 1'b1;
      @(negedge clock);
      chk("mid rst frame", lpc_frame, 1);
      chk("mid rst oe", lpc_ad_oe, 0);
      chk("mid rst rsp_valid", rsp_valid, 0);
      chk("mid rst ready", req_ready, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("mid rel ready", req_ready, 1);
      chk("mid rel rsp_valid", rsp_valid, 0);
      @(negedge clock);
      chk("mid idle rsp_valid", rsp_valid, 0);
      chk("mid idle frame", lpc_frame, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
